hash_forward_buffer: RTL

// Parametrised successor to the whole-table forward updater: per-table history of the last

---
 rtl/hash_forward_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hash_forward_buffer.sv
// Per-table write-history forwarding buffer: patches stale hash-table read data with the
// newest committed bucket write (same-cycle bypass or history hit) and counts forwards.
module hash_forward_buffer #(
  parameter int DATA_WIDTH         = 4,
  parameter int KEY_WIDTH          = 2,
  parameter int NUMBER_OF_TABLES   = 3,
  parameter int MAX_HASH_ADR_WIDTH = 2,
  parameter int FORWARD_DEPTH      = 2
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   clk_en,
  input  logic                                                   flush_i,
  input  logic [NUMBER_OF_TABLES-1:0]                            wr_en_i,
  input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]    wr_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]             wr_key_i,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]            wr_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                            wr_valid_i,
  input  logic [NUMBER_OF_TABLES-1:0]                            rd_en_i,
  input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]    rd_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]             mem_key_i,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]            mem_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                            mem_valid_i,
  output logic [NUMBER_OF_TABLES-1:0]                            corr_en_o,
  output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]             corr_key_o,
  output logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]            corr_data_o,
  output logic [NUMBER_OF_TABLES-1:0]                            corr_valid_o,
  output logic [NUMBER_OF_TABLES-1:0]                            corr_fwd_o,
  output logic [15:0]                                            hit_count_o
);

  if (FORWARD_DEPTH < 1) begin : g_bad_depth
    $error("hash_forward_buffer: FORWARD_DEPTH must be >= 1");
  end

  localparam int DEPTH = (FORWARD_DEPTH < 1) ? 1 : FORWARD_DEPTH;

  logic [NUMBER_OF_TABLES-1:0] match;
  logic [15:0]                 hit_count_reg;
  logic [15:0]                 hit_count_next;
  logic [16:0]                 hit_sum;

  genvar gi;
  for (gi = 0; gi < NUMBER_OF_TABLES; gi++) begin : g_table
    logic [DEPTH-1:0]              used_reg;
    logic [DEPTH-1:0]              used_next;
    logic [MAX_HASH_ADR_WIDTH-1:0] adr_reg   [DEPTH];
    logic [KEY_WIDTH-1:0]          key_reg   [DEPTH];
    logic [DATA_WIDTH-1:0]         data_reg  [DEPTH];
    logic                          valid_reg [DEPTH];

    logic                  lookup_hit;
    logic [KEY_WIDTH-1:0]  lookup_key;
    logic [DATA_WIDTH-1:0] lookup_data;
    logic                  lookup_valid;

    logic                  corr_en_reg;
    logic [KEY_WIDTH-1:0]  corr_key_reg;
    logic [DATA_WIDTH-1:0] corr_data_reg;
    logic                  corr_valid_reg;
    logic                  corr_fwd_reg;

    // Bypass beats history; descending scan so the lowest (newest) matching slot wins.
    always_comb begin
      lookup_hit   = 1'b0;
      lookup_key   = mem_key_i[gi];
      lookup_data  = mem_data_i[gi];
      lookup_valid = mem_valid_i[gi];
      if (wr_en_i[gi] && (wr_adr_i[gi] == rd_adr_i[gi])) begin
        lookup_hit   = 1'b1;
        lookup_key   = wr_key_i[gi];
        lookup_data  = wr_data_i[gi];
        lookup_valid = wr_valid_i[gi];
      end else if (!flush_i) begin
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (used_reg[s] && (adr_reg[s] == rd_adr_i[gi])) begin
            lookup_hit   = 1'b1;
            lookup_key   = key_reg[s];
            lookup_data  = data_reg[s];
            lookup_valid = valid_reg[s];
          end
        end
      end
    end

    // Flush clears before the shift, so a same-cycle write lands in an empty history.
    always_comb begin
      used_next = flush_i ? '0 : used_reg;
      if (wr_en_i[gi]) begin
        for (int s = DEPTH - 1; s > 0; s--) begin
          used_next[s] = flush_i ? 1'b0 : used_reg[s-1];
        end
        used_next[0] = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        used_reg       <= '0;
        corr_en_reg    <= 1'b0;
        corr_key_reg   <= '0;
        corr_data_reg  <= '0;
        corr_valid_reg <= 1'b0;
        corr_fwd_reg   <= 1'b0;
      end else if (clk_en) begin
        used_reg    <= used_next;
        corr_en_reg <= rd_en_i[gi];
        if (rd_en_i[gi]) begin
          corr_key_reg   <= lookup_key;
          corr_data_reg  <= lookup_data;
          corr_valid_reg <= lookup_valid;
          corr_fwd_reg   <= lookup_hit;
        end
      end
    end

    // Payload needs no reset: entries are only visible through used_reg.
    always_ff @(posedge clk) begin
      if (reset && clk_en && wr_en_i[gi]) begin
        for (int s = DEPTH - 1; s > 0; s--) begin
          adr_reg[s]   <= adr_reg[s-1];
          key_reg[s]   <= key_reg[s-1];
          data_reg[s]  <= data_reg[s-1];
          valid_reg[s] <= valid_reg[s-1];
        end
        adr_reg[0]   <= wr_adr_i[gi];
        key_reg[0]   <= wr_key_i[gi];
        data_reg[0]  <= wr_data_i[gi];
        valid_reg[0] <= wr_valid_i[gi];
      end
    end

    assign match[gi]        = lookup_hit;
    assign corr_en_o[gi]    = corr_en_reg;
    assign corr_key_o[gi]   = corr_key_reg;
    assign corr_data_o[gi]  = corr_data_reg;
    assign corr_valid_o[gi] = corr_valid_reg;
    assign corr_fwd_o[gi]   = corr_fwd_reg;
  end

  always_comb begin
    hit_sum = {1'b0, hit_count_reg};
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      hit_sum = hit_sum + 17'(rd_en_i[t] & match[t]);
    end
  end

  assign hit_count_next = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count_reg <= '0;
    end else if (clk_en) begin
      hit_count_reg <= hit_count_next;
    end
  end

  assign hit_count_o = hit_count_reg;

endmodule
